// File: rtl/spi_slave_shifter_pkg.sv
// Shared types and helpers for the SPI slave shifter.
// Edge selection is a pure function of the SPI mode bits.
package spi_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // Mode 0 and mode 3 sample on the rising SCLK edge
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return cpol == cpha;
    endfunction

endpackage

// File: rtl/spi_slave_shifter_if.sv
// SPI pins plus word-level data path of the slave shifter.
// The slave modport faces the design, the master modport the driver.
interface spi_slave_shifter_if #(
    parameter int WIDTH = 10
);
    logic             sclk;
    logic             cs_n;
    logic             mosi;
    logic             miso;
    logic [WIDTH-1:0] tx_data;
    logic             tx_load;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             frame_err;
    logic             busy;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_load,
        output miso, rx_data, rx_valid, frame_err, busy
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_load,
        input  miso, rx_data, rx_valid, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_shifter_sync2.sv
// Two-flop synchroniser with a selectable reset value.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/spi_slave_shifter.sv
// Oversampling SPI slave: deserialises WIDTH-bit words from MOSI
// and serialises a held transmit word on MISO, back-to-back per frame.
module spi_slave_shifter
    import spi_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit LSB_FIRST = 1'b0
) (
    input logic            clk,
    input logic            rst_n,
    spi_slave_shifter_if.slave bus
);
    localparam int             CW    = $clog2(WIDTH);
    localparam logic           SRISE = sample_on_rise(CPOL, CPHA);
    localparam logic [CW-1:0]  LAST  = CW'(WIDTH - 1);

    logic sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d;
    logic sample_p, shift_p, cs_fall_p, cs_rise_p;
    logic [1:0] warm;
    logic armed;

    state_t state, state_nx;

    logic [WIDTH-1:0] rx_shift, rx_next, rx_data_q;
    logic [WIDTH-1:0] tx_hold, tx_shift, tx_word;
    logic [CW-1:0]    bit_cnt;
    logic             fresh, rx_valid_q, frame_err_q;
    logic             active, last_bit, word_done, enter, leave, err;

    sync2 #(.RST_VAL(CPOL)) u_sclk (.clk(clk), .rst_n(rst_n), .d(bus.sclk), .q(sclk_s));
    sync2 #(.RST_VAL(1'b1)) u_cs   (.clk(clk), .rst_n(rst_n), .d(bus.cs_n), .q(cs_s));
    sync2 #(.RST_VAL(1'b0)) u_mosi (.clk(clk), .rst_n(rst_n), .d(bus.mosi), .q(mosi_s));

    // The sync chain powers up reading cs_n high, so a frame only arms
    // once cs_n is genuinely seen high after the chain has filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d    <= CPOL;
            cs_d      <= 1'b1;
            sample_p  <= 1'b0;
            shift_p   <= 1'b0;
            cs_fall_p <= 1'b0;
            cs_rise_p <= 1'b0;
            warm      <= 2'd0;
            armed     <= 1'b0;
        end else begin
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            sample_p  <= SRISE ? (sclk_s & ~sclk_d) : (~sclk_s & sclk_d);
            shift_p   <= SRISE ? (~sclk_s & sclk_d) : (sclk_s & ~sclk_d);
            cs_fall_p <= cs_d & ~cs_s;
            cs_rise_p <= ~cs_d & cs_s;
            if (warm != 2'd3) warm <= warm + 2'd1;
            if (warm == 2'd3 && cs_s) armed <= 1'b1;
        end
    end

    assign active    = (state == ACTIVE);
    assign last_bit  = (bit_cnt == LAST);
    assign word_done = active & sample_p & last_bit;
    assign enter     = (state == IDLE) & cs_fall_p & armed;
    assign leave     = active & cs_rise_p;
    assign err       = leave & ~word_done & ((bit_cnt != '0) | sample_p);
    assign tx_word   = tx_load_bypass();
    assign rx_next   = LSB_FIRST ? {mosi_s, rx_shift[WIDTH-1:1]}
                                 : {rx_shift[WIDTH-2:0], mosi_s};

    function automatic logic [WIDTH-1:0] tx_load_bypass();
        return bus.tx_load ? bus.tx_data : tx_hold;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (enter)     state_nx = ACTIVE;
            ACTIVE:  if (cs_rise_p) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift    <= '0;
            rx_data_q   <= '0;
            bit_cnt     <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            tx_hold     <= '0;
            tx_shift    <= '0;
            fresh       <= 1'b0;
        end else begin
            rx_valid_q  <= word_done;
            frame_err_q <= err;
            if (bus.tx_load) tx_hold <= bus.tx_data;
            if (word_done)   rx_data_q <= rx_next;
            if (enter || leave) begin
                rx_shift <= '0;
                bit_cnt  <= '0;
            end else if (active && sample_p) begin
                rx_shift <= rx_next;
                bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
            end
            // A freshly loaded word must hold its first bit through the
            // next shift edge so the master can sample it.
            if (enter) begin
                tx_shift <= tx_word;
                fresh    <= CPHA;
            end else if (word_done) begin
                tx_shift <= tx_word;
                fresh    <= 1'b1;
            end else if (active && shift_p) begin
                if (fresh)          fresh    <= 1'b0;
                else if (LSB_FIRST) tx_shift <= tx_shift >> 1;
                else                tx_shift <= tx_shift << 1;
            end
        end
    end

    assign bus.miso      = active ? (LSB_FIRST ? tx_shift[0] : tx_shift[WIDTH-1]) : 1'b0;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = active;
endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter in mode 0 (MSB first)
// and mode 3 (LSB first), with a bit-banged SPI master.
module tb_spi_slave_shifter;
    localparam int W = 10;
    localparam int H = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_slave_shifter_if #(.WIDTH(W)) b0 ();
    spi_slave_shifter_if #(.WIDTH(W)) b3 ();

    spi_slave_shifter #(
        .WIDTH(W), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0)
    ) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

    spi_slave_shifter #(
        .WIDTH(W), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1)
    ) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    int cyc = 0;
    int npass = 0;
    int ntotal = 0;
    int errs0 = 0;
    int errs3 = 0;
    int vcyc0 = 0;
    logic [W-1:0] rxq0[$];
    logic [W-1:0] rxq3[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (b0.rx_valid) begin
            rxq0.push_back(b0.rx_data);
            vcyc0 <= cyc;
        end
        if (b3.rx_valid) rxq3.push_back(b3.rx_data);
        if (b0.frame_err) errs0 <= errs0 + 1;
        if (b3.frame_err) errs3 <= errs3 + 1;
    end

    task automatic drv_sclk(input int sel, input logic v);
        if (sel == 0) b0.sclk = v; else b3.sclk = v;
    endtask

    task automatic drv_cs(input int sel, input logic v);
        if (sel == 0) b0.cs_n = v; else b3.cs_n = v;
    endtask

    task automatic drv_mosi(input int sel, input logic v);
        if (sel == 0) b0.mosi = v; else b3.mosi = v;
    endtask

    function automatic logic miso_of(input int sel);
        return (sel == 0) ? b0.miso : b3.miso;
    endfunction

    task automatic load_tx(input int sel, input logic [W-1:0] v);
        if (sel == 0) begin b0.tx_data = v; b0.tx_load = 1'b1; end
        else          begin b3.tx_data = v; b3.tx_load = 1'b1; end
        @(negedge clk);
        b0.tx_load = 1'b0;
        b3.tx_load = 1'b0;
    endtask

    // Clocks nbits of w; r collects MISO, ecyc is the cycle of the last sample edge
    task automatic xfer_word(input int sel, input logic cpol, input logic cpha,
                             input logic lsb, input logic [W-1:0] w, input int nbits,
                             input bit cs_last, output logic [W-1:0] r, output int ecyc);
        r = '0;
        ecyc = 0;
        for (int i = 0; i < nbits; i++) begin
            int idx = lsb ? i : W - 1 - i;
            if (!cpha) begin
                drv_mosi(sel, w[idx]);
                repeat (H) @(negedge clk);
                drv_sclk(sel, ~cpol);
                r[idx] = miso_of(sel);
                ecyc = cyc;
                if (cs_last && i == nbits - 1) drv_cs(sel, 1'b1);
                repeat (H) @(negedge clk);
                drv_sclk(sel, cpol);
            end else begin
                repeat (H) @(negedge clk);
                drv_sclk(sel, ~cpol);
                drv_mosi(sel, w[idx]);
                repeat (H) @(negedge clk);
                drv_sclk(sel, cpol);
                r[idx] = miso_of(sel);
                ecyc = cyc;
                if (cs_last && i == nbits - 1) drv_cs(sel, 1'b1);
            end
        end
    endtask

    task automatic frame(input int sel, input logic cpol, input logic cpha,
                         input logic lsb, input logic [W-1:0] w,
                         output logic [W-1:0] r, output int ecyc);
        drv_cs(sel, 1'b0);
        repeat (H) @(negedge clk);
        xfer_word(sel, cpol, cpha, lsb, w, W, 1'b0, r, ecyc);
        repeat (H) @(negedge clk);
        drv_cs(sel, 1'b1);
        repeat (3 * H) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        ntotal++; if (b0.rx_data !== '0) $display("FAIL rst_rx_data: got %h want 0", b0.rx_data); else npass++;
        ntotal++; if (b0.rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b want 0", b0.rx_valid); else npass++;
        ntotal++; if (b0.frame_err !== 1'b0) $display("FAIL rst_frame_err: got %b want 0", b0.frame_err); else npass++;
        ntotal++; if (b0.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", b0.busy); else npass++;
        ntotal++; if (b0.miso !== 1'b0) $display("FAIL rst_miso: got %b want 0", b0.miso); else npass++;
        ntotal++; if (b3.miso !== 1'b0) $display("FAIL rst_miso3: got %b want 0", b3.miso); else npass++;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_mode0();
        logic [W-1:0] r;
        int e;
        int n0 = rxq0.size();
        frame(0, 1'b0, 1'b0, 1'b0, 10'h2A5, r, e);
        ntotal++; if (rxq0.size() - n0 !== 1) $display("FAIL m0_pulses: got %0d want 1", rxq0.size() - n0); else npass++;
        ntotal++; if (b0.rx_data !== 10'h2A5) $display("FAIL m0_rx_data: got %h want 2a5", b0.rx_data); else npass++;
        ntotal++; if (vcyc0 - e !== 4) $display("FAIL m0_latency: got %0d want 4", vcyc0 - e); else npass++;
    endtask

    task automatic test_mode3();
        logic [W-1:0] r;
        int e;
        int n3 = rxq3.size();
        load_tx(3, 10'h155);
        frame(3, 1'b1, 1'b1, 1'b1, 10'h0F0, r, e);
        ntotal++; if (rxq3.size() - n3 !== 1) $display("FAIL m3_pulses: got %0d want 1", rxq3.size() - n3); else npass++;
        ntotal++; if (b3.rx_data !== 10'h0F0) $display("FAIL m3_rx_data: got %h want 0f0", b3.rx_data); else npass++;
        ntotal++; if (r !== 10'h155) $display("FAIL m3_miso: got %h want 155", r); else npass++;
        ntotal++; if (errs3 !== 0) $display("FAIL m3_frame_err: got %0d want 0", errs3); else npass++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r1, r2, r3;
        int e;
        int n0 = rxq0.size();
        load_tx(0, 10'h3A5);
        fork
            begin
                drv_cs(0, 1'b0);
                repeat (H) @(negedge clk);
                xfer_word(0, 1'b0, 1'b0, 1'b0, 10'h001, W, 1'b0, r1, e);
                xfer_word(0, 1'b0, 1'b0, 1'b0, 10'h3FF, W, 1'b0, r2, e);
                xfer_word(0, 1'b0, 1'b0, 1'b0, 10'h200, W, 1'b0, r3, e);
                repeat (H) @(negedge clk);
                drv_cs(0, 1'b1);
                repeat (3 * H) @(negedge clk);
            end
            begin
                repeat (60) @(negedge clk);
                load_tx(0, 10'h05A);
            end
        join
        ntotal++; if (rxq0.size() - n0 !== 3) $display("FAIL b2b_pulses: got %0d want 3", rxq0.size() - n0); else npass++;
        if (rxq0.size() - n0 == 3) begin
            ntotal++; if (rxq0[n0] !== 10'h001) $display("FAIL b2b_w0: got %h want 001", rxq0[n0]); else npass++;
            ntotal++; if (rxq0[n0+1] !== 10'h3FF) $display("FAIL b2b_w1: got %h want 3ff", rxq0[n0+1]); else npass++;
            ntotal++; if (rxq0[n0+2] !== 10'h200) $display("FAIL b2b_w2: got %h want 200", rxq0[n0+2]); else npass++;
        end
        ntotal++; if (r1 !== 10'h3A5) $display("FAIL b2b_miso0: got %h want 3a5", r1); else npass++;
        ntotal++; if (r2 !== 10'h05A) $display("FAIL b2b_miso1: got %h want 05a", r2); else npass++;
        ntotal++; if (r3 !== 10'h05A) $display("FAIL b2b_miso2: got %h want 05a", r3); else npass++;
        ntotal++; if (errs0 !== 0) $display("FAIL b2b_frame_err: got %0d want 0", errs0); else npass++;
    endtask

    task automatic test_short_frame();
        logic [W-1:0] r;
        int e;
        int n0 = rxq0.size();
        int f0 = errs0;
        drv_cs(0, 1'b0);
        repeat (H) @(negedge clk);
        xfer_word(0, 1'b0, 1'b0, 1'b0, 10'h0CC, 6, 1'b0, r, e);
        repeat (H) @(negedge clk);
        drv_cs(0, 1'b1);
        repeat (4 * H) @(negedge clk);
        ntotal++; if (errs0 - f0 !== 1) $display("FAIL short_err: got %0d want 1", errs0 - f0); else npass++;
        ntotal++; if (rxq0.size() !== n0) $display("FAIL short_no_valid: got %0d want %0d", rxq0.size(), n0); else npass++;
        ntotal++; if (b0.rx_data !== 10'h200) $display("FAIL short_rx_hold: got %h want 200", b0.rx_data); else npass++;
        frame(0, 1'b0, 1'b0, 1'b0, 10'h1C7, r, e);
        ntotal++; if (b0.rx_data !== 10'h1C7) $display("FAIL short_next: got %h want 1c7", b0.rx_data); else npass++;
        ntotal++; if (errs0 - f0 !== 1) $display("FAIL short_next_err: got %0d want 1", errs0 - f0); else npass++;
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] r;
        int e;
        int n0 = rxq0.size();
        int f0 = errs0;
        drv_cs(0, 1'b0);
        repeat (H) @(negedge clk);
        xfer_word(0, 1'b0, 1'b0, 1'b0, 10'h356, W, 1'b1, r, e);
        repeat (4 * H) @(negedge clk);
        ntotal++; if (rxq0.size() - n0 !== 1) $display("FAIL sim_pulses: got %0d want 1", rxq0.size() - n0); else npass++;
        ntotal++; if (b0.rx_data !== 10'h356) $display("FAIL sim_rx_data: got %h want 356", b0.rx_data); else npass++;
        ntotal++; if (errs0 !== f0) $display("FAIL sim_frame_err: got %0d want %0d", errs0, f0); else npass++;
        ntotal++; if (b0.busy !== 1'b0) $display("FAIL sim_busy: got %b want 0", b0.busy); else npass++;
    endtask

    task automatic test_reset_midframe();
        logic [W-1:0] r;
        int e;
        int n0, f0;
        drv_cs(0, 1'b0);
        repeat (H) @(negedge clk);
        xfer_word(0, 1'b0, 1'b0, 1'b0, 10'h3C3, 4, 1'b0, r, e);
        rst_n = 1'b0;
        @(negedge clk);
        ntotal++; if (b0.busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", b0.busy); else npass++;
        ntotal++; if (b0.rx_data !== '0) $display("FAIL mid_rst_rx_data: got %h want 0", b0.rx_data); else npass++;
        ntotal++; if (b0.miso !== 1'b0) $display("FAIL mid_rst_miso: got %b want 0", b0.miso); else npass++;
        ntotal++; if (b0.rx_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", b0.rx_valid); else npass++;
        @(negedge clk);
        rst_n = 1'b1;
        n0 = rxq0.size();
        f0 = errs0;
        xfer_word(0, 1'b0, 1'b0, 1'b0, 10'h3FF, 6, 1'b0, r, e);
        repeat (H) @(negedge clk);
        ntotal++; if (b0.busy !== 1'b0) $display("FAIL mid_ignored_busy: got %b want 0", b0.busy); else npass++;
        ntotal++; if (rxq0.size() !== n0) $display("FAIL mid_ignored_valid: got %0d want %0d", rxq0.size(), n0); else npass++;
        drv_cs(0, 1'b1);
        repeat (4 * H) @(negedge clk);
        ntotal++; if (errs0 !== f0) $display("FAIL mid_no_err: got %0d want %0d", errs0, f0); else npass++;
        frame(0, 1'b0, 1'b0, 1'b0, 10'h0AB, r, e);
        ntotal++; if (b0.rx_data !== 10'h0AB) $display("FAIL mid_next: got %h want 0ab", b0.rx_data); else npass++;
        ntotal++; if (rxq0.size() - n0 !== 1) $display("FAIL mid_next_pulses: got %0d want 1", rxq0.size() - n0); else npass++;
    endtask

    initial begin
        b0.sclk = 1'b0; b0.cs_n = 1'b1; b0.mosi = 1'b0;
        b0.tx_data = '0; b0.tx_load = 1'b0;
        b3.sclk = 1'b1; b3.cs_n = 1'b1; b3.mosi = 1'b0;
        b3.tx_data = '0; b3.tx_load = 1'b0;
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_short_frame();
        test_simultaneous();
        test_reset_midframe();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
